// File: rtl/demux_1_8_deser.sv
// demux_1_8_deser: bit-serial to byte converter.
// A 3-bit position counter steers each accepted serial bit into one
// position of an 8-bit byte register. The finished byte is offered on a
// valid/ready output port.
// Optional build macro: DEMUX_PARITY_EN. It adds a 9th serial bit carrying
// even parity over the byte, and drives the parity_err output.
//
// Handshake rules:
//   - Input side: a bit is consumed when in_valid && in_ready at a rising
//     clk edge. in_ready depends only on state (and reset), never on
//     in_valid. A bit offered while in_ready=0 is not consumed, so the
//     sender must hold it.
//   - Output side: a byte is consumed when out_valid && out_ready at a
//     rising clk edge. out_valid is registered. out_data is stable while
//     out_valid=1.
module demux_1_8_deser #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] idx,
   output logic       parity_err
);

   // PAR is only reachable when the parity bit is enabled.
   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      PAR  = 2'd2
   } state_t;

   state_t     state, state_n;
   logic [2:0] idx_q, idx_n;
   logic [7:0] data_q, data_n;
   logic [2:0] pos;
   logic       accept;

`ifdef DEMUX_PARITY_EN
   logic       perr_q, perr_n;
`endif

   // Byte position written by the next accepted bit.
   assign pos    = LSB_FIRST ? idx_q : (3'd7 - idx_q);
   assign accept = in_valid && in_ready;

   assign in_ready  = ((state == FILL) || (state == PAR)) && !reset;
   assign out_valid = (state == HOLD);
   assign out_data  = data_q;
   assign idx       = idx_q;

`ifdef DEMUX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   // Next-state logic: flush beats accept; a held byte ignores flush.
   always_comb begin
      state_n = state;
      idx_n   = idx_q;
      data_n  = data_q;
`ifdef DEMUX_PARITY_EN
      perr_n  = perr_q;
`endif
      case (state)
         FILL: begin
            if (flush) begin
               idx_n  = 3'd0;
               data_n = 8'h00;
`ifdef DEMUX_PARITY_EN
               perr_n = 1'b0;
`endif
            end else if (accept) begin
               data_n[pos] = in_bit;
               // idx wraps to 0 after the 8th bit.
               idx_n = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef DEMUX_PARITY_EN
                  state_n = PAR;
`else
                  state_n = HOLD;
`endif
               end
            end
         end
`ifdef DEMUX_PARITY_EN
         PAR: begin
            if (flush) begin
               state_n = FILL;
               idx_n   = 3'd0;
               data_n  = 8'h00;
               perr_n  = 1'b0;
            end else if (accept) begin
               // Even parity: in_bit must equal the XOR of the data bits.
               perr_n  = in_bit ^ (^data_q);
               state_n = HOLD;
            end
         end
`endif
         HOLD: begin
            if (out_ready) begin
               state_n = FILL;
               data_n  = 8'h00;
`ifdef DEMUX_PARITY_EN
               perr_n  = 1'b0;
`endif
            end
         end
         default: begin
            state_n = FILL;
            idx_n   = 3'd0;
            data_n  = 8'h00;
         end
      endcase
   end

   // State register with synchronous reset; reset discards any partial or held byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FILL;
         idx_q  <= 3'd0;
         data_q <= 8'h00;
`ifdef DEMUX_PARITY_EN
         perr_q <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         idx_q  <= idx_n;
         data_q <= data_n;
`ifdef DEMUX_PARITY_EN
         perr_q <= perr_n;
`endif
      end
   end

endmodule

// File: tb/tb_demux_1_8_deser.sv
// tb_demux_1_8_deser: bench for demux_1_8_deser.
// It drives two instances from the same inputs: LSB_FIRST=1 (suffix _a)
// and LSB_FIRST=0 (suffix _b). A queue-based reference model predicts
// every output each cycle. The bench covers directed table vectors,
// hand-written corner sequences and randomized traffic.
module tb_demux_1_8_deser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, flush, in_valid, in_bit, out_ready;
   logic       rdy_a, val_a, perr_a, rdy_b, val_b, perr_b;
   logic [7:0] data_a, data_b;
   logic [2:0] idx_a, idx_b;

   demux_1_8_deser #(.LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(rdy_a), .out_data(data_a), .out_valid(val_a), .out_ready(out_ready),
      .idx(idx_a), .parity_err(perr_a)
   );

   demux_1_8_deser #(.LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(rdy_b), .out_data(data_b), .out_valid(val_b), .out_ready(out_ready),
      .idx(idx_b), .parity_err(perr_b)
   );

`ifdef DEMUX_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state.
   // bits: serial bits accepted so far for the current byte, oldest first.
   bit         bits[$];
   bit         holding = 1'b0;
   logic [7:0] hold_a = 8'h00, hold_b = 8'h00;
   bit         hold_perr = 1'b0;

   // Build a byte from the accepted bits: bit i goes to i (lsb) or 7-i.
   function automatic logic [7:0] pack(input bit lsb);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < bits.size() && i < 8; i++)
         if (bits[i]) v = v | (8'd1 << (lsb ? i : 7 - i));
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare both DUTs against the model's prediction for this cycle.
   task automatic check_model();
      logic [7:0] ea, eb;
      logic [2:0] ei;
      ea = holding ? hold_a : pack(1'b1);
      eb = holding ? hold_b : pack(1'b0);
      ei = holding ? 3'd0 : 3'(bits.size() % 8);
      chk("in_ready_a",   {7'd0, rdy_a},  {7'd0, !holding && !reset});
      chk("in_ready_b",   {7'd0, rdy_b},  {7'd0, !holding && !reset});
      chk("out_valid_a",  {7'd0, val_a},  {7'd0, holding});
      chk("out_valid_b",  {7'd0, val_b},  {7'd0, holding});
      chk("out_data_a",   data_a, ea);
      chk("out_data_b",   data_b, eb);
      chk("idx_a",        {5'd0, idx_a},  {5'd0, ei});
      chk("idx_b",        {5'd0, idx_b},  {5'd0, ei});
      chk("parity_err_a", {7'd0, perr_a}, {7'd0, holding && hold_perr});
      chk("parity_err_b", {7'd0, perr_b}, {7'd0, holding && hold_perr});
   endtask

   // Advance the model by one clock edge using the inputs just applied.
   task automatic model_step();
      if (reset) begin
         bits.delete();
         holding   = 1'b0;
         hold_perr = 1'b0;
      end else if (holding) begin
         if (out_ready) begin
            holding   = 1'b0;
            hold_perr = 1'b0;
         end
      end else if (flush) begin
         bits.delete();
      end else if (in_valid) begin
         bits.push_back(in_bit);
         if (bits.size() == NB) begin
            hold_a    = pack(1'b1);
            hold_b    = pack(1'b0);
            hold_perr = (NB == 9) ? (bits[NB-1] != ($countones(hold_a) % 2 == 1)) : 1'b0;
            holding   = 1'b1;
            bits.delete();
         end
      end
   endtask

   task automatic begin_cycle(input bit r, input bit f, input bit v, input bit b, input bit o);
      reset = r; flush = f; in_valid = v; in_bit = b; out_ready = o;
      @(negedge clk);
      check_model();
   endtask

   task automatic end_cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cycle(input bit r, input bit f, input bit v, input bit b, input bit o);
      begin_cycle(r, f, v, b, o);
      end_cycle();
   endtask

   typedef struct {
      bit         rst, fl, v, b, o;
      logic [2:0] e_idx;
      logic [7:0] e_a, e_b;
      bit         e_val, e_rdy;
   } vec_t;

   function automatic vec_t mk(input bit rst, input bit fl, input bit v, input bit b, input bit o,
                               input logic [2:0] e_idx, input logic [7:0] e_a, input logic [7:0] e_b,
                               input bit e_val, input bit e_rdy);
      vec_t t;
      t.rst = rst; t.fl = fl; t.v = v; t.b = b; t.o = o;
      t.e_idx = e_idx; t.e_a = e_a; t.e_b = e_b; t.e_val = e_val; t.e_rdy = e_rdy;
      return t;
   endfunction

   initial begin
      vec_t tbl[$];
      logic [8:0] pat;

      // First edge: reset from unknown power-up state, nothing to check yet.
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      model_step();
      #1;

`ifndef DEMUX_PARITY_EN
      // Directed vectors. Expected values are the outputs seen before the edge.
      tbl.push_back(mk(1,0,0,0,0, 3'd0, 8'h00, 8'h00, 0, 0)); // 2nd reset cycle
      tbl.push_back(mk(0,0,1,1,1, 3'd0, 8'h00, 8'h00, 0, 1)); // stream 1,0,1,1,0,0,1,0
      tbl.push_back(mk(0,0,1,0,1, 3'd1, 8'h01, 8'h80, 0, 1));
      tbl.push_back(mk(0,0,1,1,1, 3'd2, 8'h01, 8'h80, 0, 1));
      tbl.push_back(mk(0,0,1,1,1, 3'd3, 8'h05, 8'hA0, 0, 1));
      tbl.push_back(mk(0,0,1,0,1, 3'd4, 8'h0D, 8'hB0, 0, 1));
      tbl.push_back(mk(0,0,1,0,1, 3'd5, 8'h0D, 8'hB0, 0, 1));
      tbl.push_back(mk(0,0,1,1,1, 3'd6, 8'h0D, 8'hB0, 0, 1));
      tbl.push_back(mk(0,0,1,0,1, 3'd7, 8'h4D, 8'hB2, 0, 1));
      tbl.push_back(mk(0,0,1,1,1, 3'd0, 8'h4D, 8'hB2, 1, 0)); // handoff, bit not taken
      tbl.push_back(mk(0,0,1,1,1, 3'd0, 8'h00, 8'h00, 0, 1)); // next byte starts
      tbl.push_back(mk(0,0,1,1,1, 3'd1, 8'h01, 8'h80, 0, 1));
      tbl.push_back(mk(0,0,1,1,1, 3'd2, 8'h03, 8'hC0, 0, 1));
      tbl.push_back(mk(0,1,1,1,1, 3'd3, 8'h07, 8'hE0, 0, 1)); // flush at idx 3
      tbl.push_back(mk(0,0,0,0,0, 3'd0, 8'h00, 8'h00, 0, 1)); // flushed, bit discarded
      for (int i = 0; i < tbl.size(); i++) begin
         begin_cycle(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].b, tbl[i].o);
         chk("tbl_idx_a",  {5'd0, idx_a}, {5'd0, tbl[i].e_idx});
         chk("tbl_data_a", data_a, tbl[i].e_a);
         chk("tbl_data_b", data_b, tbl[i].e_b);
         chk("tbl_valid",  {7'd0, val_a}, {7'd0, tbl[i].e_val});
         chk("tbl_ready",  {7'd0, rdy_a}, {7'd0, tbl[i].e_rdy});
         end_cycle();
      end
`endif

      // Backpressure on a full 0xFF byte, with a flush landing in HOLD.
      cycle(1,0,0,0,0);
      begin_cycle(0,0,0,0,0);
      chk("post_reset_ready", {7'd0, rdy_a}, 8'd1);
      end_cycle();
      for (int i = 0; i < NB; i++) cycle(0,0,1,1,0);
      for (int i = 0; i < 5; i++) begin
         begin_cycle(0, (i == 2), 1, 0, 0);
         chk("bp_data",  data_a, 8'hFF);
         chk("bp_valid", {7'd0, val_a}, 8'd1);
         chk("bp_ready", {7'd0, rdy_a}, 8'd0);
         chk("bp_idx",   {5'd0, idx_a}, 8'd0);
         end_cycle();
      end
      cycle(0,0,1,0,1);                          // handoff
      begin_cycle(0,0,0,0,0);
      chk("after_handoff_ready", {7'd0, rdy_a}, 8'd1);
      chk("after_handoff_data",  data_a, 8'h00);
      end_cycle();

      // Flush with three ones accepted, then a byte of zeros.
      for (int i = 0; i < 3; i++) cycle(0,0,1,1,0);
      cycle(0,1,1,1,0);
      for (int i = 0; i < NB; i++) cycle(0,0,1,0,0);
      begin_cycle(0,0,0,0,0);
      chk("zero_byte_valid", {7'd0, val_a}, 8'd1);
      chk("zero_byte_data",  data_a, 8'h00);
      chk("zero_byte_data_b", data_b, 8'h00);
      end_cycle();
      cycle(0,0,0,0,1);

`ifdef DEMUX_PARITY_EN
      // 0x4D has four ones: parity bit 0 is good, parity bit 1 is an error.
      pat = 9'b0_0100_1101;
      for (int i = 0; i < 9; i++) cycle(0,0,1,pat[i],0);
      begin_cycle(0,0,0,0,0);
      chk("par_good_err", {7'd0, perr_a}, 8'd0);
      chk("par_good_val", {7'd0, val_a}, 8'd1);
      end_cycle();
      cycle(0,0,0,0,1);
      pat = 9'b1_0100_1101;
      for (int i = 0; i < 9; i++) cycle(0,0,1,pat[i],0);
      begin_cycle(0,0,0,0,1);
      chk("par_bad_err",  {7'd0, perr_a}, 8'd1);
      chk("par_bad_data", data_a, 8'h4D);
      end_cycle();
      begin_cycle(0,0,0,0,0);
      chk("par_cleared", {7'd0, perr_a}, 8'd0);
      end_cycle();
`else
      pat = 9'h000;
`endif

      // Randomized traffic checked against the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom),
               ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/demux_1_8_deser.md
Name: demux_1_8_deser

Overview:
- Bit-serial to byte converter. Receiving end of the 8:1 bit-select path.
- A 3-bit position counter drives a 1:8 demux that steers each accepted serial bit into one of eight byte-register positions.
- A completed byte is presented on a valid/ready output port.
- Sits between the serial operand link and the 8-bit slice inputs of the ALU datapath.

Parameters:
- LSB_FIRST, 1, 1: first accepted bit lands in out_data[0] (position 0, counting up). 0: first bit lands in out_data[7] (counting down).

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous abort of a partial byte
- in_valid  input  1  serial bit present
- in_bit  input  1  serial data bit
- in_ready  output  1  block can accept in_bit this cycle
- out_data  output  8  assembled byte
- out_valid  output  1  out_data holds a complete byte
- out_ready  input  1  consumer accepts byte
- idx  output  3  current demux position (bits accepted so far in this byte)
- parity_err  output  1  present only with DEMUX_PARITY_EN; tied 0 otherwise

Behaviour:
- Interface: clock is clk; reset is synchronous, active-high, named reset.
- Reset, sampled on a clk edge, sets:
  - state=FILL, idx=0, out_data=8'h00, out_valid=0, parity_err=0.
  - in_ready is forced 0 in any cycle where reset=1.
- Accept condition: in_valid && in_ready at a clk edge.
- in_ready = (state==FILL) && !reset. It is combinational from state, with no dependency on in_valid.
- out_valid = (state==HOLD). It is registered.
- State FILL:
  - On each accept, in_bit is written to position p and idx increments.
  - p = idx when LSB_FIRST=1; p = 7-idx when LSB_FIRST=0.
  - Only position p is written. All other bits hold.
  - Accept with idx==7: write the bit, idx wraps to 0, next state HOLD. out_valid rises the cycle after the 8th accept.
  - No accept: all state holds.
- State HOLD:
  - in_ready=0 and out_data is stable.
  - out_valid && out_ready: next state FILL, out_data cleared to 8'h00. in_ready rises the next cycle.
  - Minimum cadence is 9 cycles per byte (8 accepts + 1 handoff).
- out_ready while not in HOLD is ignored.
- in_valid while in_ready=0 is ignored. The bit is not consumed, and the sender must hold it.
- flush (FILL only):
  - Sets idx=0 and out_data=8'h00. Any accept in the same cycle is discarded.
  - flush in HOLD is ignored; a complete byte is never dropped.
- Priority: reset > flush > accept/handoff.
- Reset mid-byte or during HOLD: the partial or held byte is discarded and out_valid=0 next cycle.
- idx reflects bits accepted in the current byte: 0..7 in FILL, and 0 in HOLD.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - A 9th serial bit (even parity over the 8 data bits) is expected after position 7.
  - Adds state PAR between FILL and HOLD. The 8th accept goes to PAR with in_ready still 1.
  - The accept in PAR compares in_bit against the XOR of out_data. parity_err is set to (mismatch), and the state goes to HOLD.
  - parity_err is valid while out_valid=1 and clears on handoff, reset, or flush.
  - flush in PAR behaves as in FILL.
  - Cadence becomes 10 cycles per byte.
- Undefined: no PAR state; parity_err is constant 0.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then release -> out_data=00, out_valid=0, idx=0, in_ready=0 during reset and 1 the cycle after release.
- LSB_FIRST=1, stream 1,0,1,1,0,0,1,0 back-to-back, out_ready=1 -> out_valid for exactly 1 cycle with out_data=8'h4D, in_ready=0 that cycle, next byte accepted the following cycle.
- LSB_FIRST=0, same stream -> out_data=8'hB2.
- Backpressure: byte 8'hFF complete, out_ready=0 for 5 cycles while in_valid=1 -> out_valid stays 1, out_data stays FF, no bits consumed, idx=0; out_ready=1 -> handoff, then FILL.
- Flush at idx=3 (bits 1,1,1 accepted) with in_valid=1 -> idx=0, out_data=00, that bit discarded; then 8 zeros -> out_data=8'h00. Flush during HOLD -> byte retained.
- DEMUX_PARITY_EN: data 8'h4D (four 1s) with parity bit 0 -> parity_err=0; same data with parity bit 1 -> parity_err=1 alongside out_valid, cleared after handoff.
